// File: rtl/r_type_exec_unit.sv
// r_type_exec_unit: RV R-type execute stage. Base ALU ops finish in one cycle,
// M-extension multiplies take one extra cycle, divides run a restoring
// 1-bit-per-cycle loop. One operation in flight, valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds its payload stable while valid=1 and ready=0, and
// the result side (out/out_rd/illegal) stays frozen until out_ready is seen.
module r_type_exec_unit #(
   parameter int XLEN = 32,
   parameter bit EN_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] in1,
   input  logic [XLEN-1:0] in2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out,
   output logic [4:0]      out_rd,
   output logic            illegal
);

   localparam int SHW   = $clog2(XLEN);
   localparam int CNT_W = SHW;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_RESP} state_t;

   // Registered state
   state_t            state_q, state_d;
   logic [XLEN-1:0]   out_q, out_d;
   logic [4:0]        out_rd_q, out_rd_d;
   logic              illegal_q, illegal_d;
   logic [2:0]        f3_q, f3_d;
   logic [XLEN-1:0]   op_a_q, op_a_d;   // MUL: rs1; DIV: dividend magnitude / quotient shift reg
   logic [XLEN-1:0]   op_b_q, op_b_d;   // MUL: rs2; DIV: divisor magnitude
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              neg_quo_q, neg_quo_d;
   logic              neg_rem_q, neg_rem_d;

   // Instruction fields
   logic [6:0]        opcode;
   logic [2:0]        f3;
   logic [6:0]        f7;
   logic [SHW-1:0]    shamt;

   assign opcode = instr[6:0];
   assign f3     = instr[14:12];
   assign f7     = instr[31:25];
   assign shamt  = in2[SHW-1:0];

   // Decode results
   logic              is_alu, is_mul, is_div, illegal_dec;
   logic [XLEN-1:0]   alu_res;

   // Decode the instruction word and evaluate the single-cycle ALU result
   always_comb begin
      is_alu  = 1'b0;
      is_mul  = 1'b0;
      is_div  = 1'b0;
      alu_res = '0;
      if (opcode == 7'h33) begin
         case (f7)
            7'b0000000: begin
               is_alu = 1'b1;
               case (f3)
                  3'b000:  alu_res = in1 + in2;
                  3'b001:  alu_res = in1 << shamt;
                  3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
                  3'b011:  alu_res = {{(XLEN-1){1'b0}}, (in1 < in2)};
                  3'b100:  alu_res = in1 ^ in2;
                  3'b101:  alu_res = in1 >> shamt;
                  3'b110:  alu_res = in1 | in2;
                  default: alu_res = in1 & in2;
               endcase
            end
            7'b0100000: begin
               if (f3 == 3'b000) begin
                  is_alu  = 1'b1;
                  alu_res = in1 - in2;
               end else if (f3 == 3'b101) begin
                  is_alu  = 1'b1;
                  alu_res = $unsigned($signed(in1) >>> shamt);
               end
            end
            7'b0000001: begin
               if (EN_M) begin
                  is_mul = !f3[2];
                  is_div = f3[2];
               end
            end
            default: ;
         endcase
      end
      illegal_dec = !(is_alu || is_mul || is_div);
   end

   // Divide setup: f3[0]=1 unsigned, f3[1]=1 remainder
   logic              div_signed, div_is_rem, neg_a, neg_b;
   logic              div_by_zero, div_ovf;
   logic [XLEN-1:0]   mag_a, mag_b, div_special;
   logic [XLEN-1:0]   min_val;

   assign min_val     = {1'b1, {(XLEN-1){1'b0}}};
   assign div_signed  = !f3[0];
   assign div_is_rem  = f3[1];
   assign neg_a       = div_signed && in1[XLEN-1];
   assign neg_b       = div_signed && in2[XLEN-1];
   assign mag_a       = neg_a ? (~in1 + 1'b1) : in1;
   assign mag_b       = neg_b ? (~in2 + 1'b1) : in2;
   assign div_by_zero = (in2 == '0);
   assign div_ovf     = div_signed && (in1 == min_val) && (in2 == '1);

   // Results that bypass the iterative loop (divide by zero, signed overflow)
   always_comb begin
      div_special = '0;
      if (div_by_zero) begin
         div_special = div_is_rem ? in1 : '1;
      end else if (div_ovf) begin
         div_special = div_is_rem ? '0 : min_val;
      end
   end

   // Multiplier: operands extended per RV signedness to a 2*XLEN+2 product
   logic                     mul_sa, mul_sb;
   logic signed [2*XLEN+1:0] mul_a_w, mul_b_w, prod;
   logic [XLEN-1:0]          mul_res;

   assign mul_sa  = (f3_q == 3'b001) || (f3_q == 3'b010);
   assign mul_sb  = (f3_q == 3'b001);
   assign mul_a_w = {{(XLEN+2){mul_sa && op_a_q[XLEN-1]}}, op_a_q};
   assign mul_b_w = {{(XLEN+2){mul_sb && op_b_q[XLEN-1]}}, op_b_q};
   assign prod    = mul_a_w * mul_b_w;
   assign mul_res = (f3_q == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

   // One restoring-divide step on the magnitudes
   logic [XLEN:0]     rem_sh, rem_diff;
   logic              take;
   logic [XLEN-1:0]   rem_nx, quo_nx, quo_fin, rem_fin;

   assign rem_sh   = {rem_q, op_a_q[XLEN-1]};
   assign rem_diff = rem_sh - {1'b0, op_b_q};
   assign take     = !rem_diff[XLEN];
   assign rem_nx   = take ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
   assign quo_nx   = {op_a_q[XLEN-2:0], take};
   assign quo_fin  = neg_quo_q ? (~quo_nx + 1'b1) : quo_nx;
   assign rem_fin  = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;

   logic unused_bits;
   assign unused_bits = ^{instr[24:15], prod[2*XLEN+1:2*XLEN]};

   logic accept, start;

   assign in_ready  = !rst && ((state_q == S_IDLE) || ((state_q == S_RESP) && out_ready));
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_RESP);
   assign out       = out_q;
   assign out_rd    = out_rd_q;
   assign illegal   = illegal_q;

   // Next-state and datapath register updates
   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      out_rd_d  = out_rd_q;
      illegal_d = illegal_q;
      f3_d      = f3_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      rem_d     = rem_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      start     = 1'b0;

      case (state_q)
         S_IDLE: start = accept;
         S_MUL: begin
            out_d   = mul_res;
            state_d = S_RESP;
         end
         S_DIV: begin
            op_a_d = quo_nx;
            rem_d  = rem_nx;
            if (cnt_q == CNT_W'(XLEN-1)) begin
               out_d   = f3_q[1] ? rem_fin : quo_fin;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            if (out_ready) begin
               state_d = S_IDLE;
               start   = accept;
            end
         end
      endcase

      if (start) begin
         out_rd_d  = instr[11:7];
         illegal_d = 1'b0;
         f3_d      = f3;
         if (illegal_dec) begin
            out_d     = '0;
            illegal_d = 1'b1;
            state_d   = S_RESP;
         end else if (is_alu) begin
            out_d   = alu_res;
            state_d = S_RESP;
         end else if (is_mul) begin
            op_a_d  = in1;
            op_b_d  = in2;
            state_d = S_MUL;
         end else if (div_by_zero || div_ovf) begin
            out_d   = div_special;
            state_d = S_RESP;
         end else begin
            op_a_d    = mag_a;
            op_b_d    = mag_b;
            rem_d     = '0;
            cnt_d     = '0;
            neg_quo_d = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            state_d   = S_DIV;
         end
      end
   end

   // State register with synchronous reset; reset aborts any op in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         out_q     <= '0;
         out_rd_q  <= '0;
         illegal_q <= 1'b0;
         f3_q      <= '0;
         op_a_q    <= '0;
         op_b_q    <= '0;
         rem_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         out_rd_q  <= out_rd_d;
         illegal_q <= illegal_d;
         f3_q      <= f3_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         rem_q     <= rem_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
      end
   end

endmodule

// File: tb/tb_r_type_exec_unit.sv
// Directed bench for r_type_exec_unit (XLEN=32, EN_M=1).
module tb_r_type_exec_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] in1;
   logic [31:0] in2;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;
   logic [4:0]  out_rd;
   logic        illegal;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   r_type_exec_unit #(.XLEN(32), .EN_M(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .instr     (instr),
      .in1       (in1),
      .in2       (in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out),
      .out_rd    (out_rd),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   // Advance one clock; outputs are sampled 1ns after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one op for exactly one accept edge
   task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
      instr    = i;
      in1      = a;
      in2      = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      instr    = 32'h0;
      in1      = 32'hDEAD_BEEF;
      in2      = 32'hDEAD_BEEF;
   endtask

   // Count edges after the accept edge until out_valid, bounded
   task automatic wait_valid(input int max_cycles, output int n);
      n = 0;
      while (!out_valid && n < max_cycles) begin
         step();
         n++;
      end
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_drained"}, {31'b0, out_valid}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [31:0] exp_out);
      int n;
      issue(i, a, b);
      wait_valid(40, n);
      chk({tag, "_lat"}, n, exp_lat);
      chk({tag, "_out"}, out, exp_out);
      chk({tag, "_illegal"}, {31'b0, illegal}, 32'd0);
      drain(tag);
   endtask

   initial begin
      int n;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr     = 32'h0;
      in1       = 32'h0;
      in2       = 32'h0;

      // Reset
      step();
      step();
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out", out, 32'd0);
      chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
      chk("rst_illegal", {31'b0, illegal}, 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

      // ADD with full output check
      issue(32'h002081B3, 32'd5, 32'd7);
      chk("add_valid", {31'b0, out_valid}, 32'd1);
      chk("add_out", out, 32'd12);
      chk("add_rd", {27'b0, out_rd}, 32'd3);
      chk("add_illegal", {31'b0, illegal}, 32'd0);
      drain("add");

      // Base ALU ops
      run_op("sub",  32'h402081B3, 32'd3,        32'd5,  0, 32'hFFFF_FFFE);
      run_op("sra",  32'h4020D1B3, 32'h8000_0000, 32'h24, 0, 32'hF800_0000);
      run_op("srl",  32'h0020D1B3, 32'h8000_0000, 32'h24, 0, 32'h0800_0000);
      run_op("sll",  32'h002091B3, 32'h0000_0003, 32'h21, 0, 32'h0000_0006);
      run_op("slt",  32'h0020A1B3, 32'hFFFF_FFFF, 32'd1,  0, 32'd1);
      run_op("sltu", 32'h0020B1B3, 32'hFFFF_FFFF, 32'd1,  0, 32'd0);
      run_op("xor",  32'h0020C1B3, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'hFF00_EDCB);
      run_op("or",   32'h0020E1B3, 32'hF000_0001, 32'h0000_0F00, 0, 32'hF000_0F01);
      run_op("and",  32'h0020F1B3, 32'hF0F0_1234, 32'h0FF0_FFFF, 0, 32'h00F0_1234);

      // Multiplies: busy for one cycle after accept
      issue(32'h0220B1B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mulhu_busy_in_ready", {31'b0, in_ready}, 32'd0);
      wait_valid(40, n);
      chk("mulhu_lat", n, 1);
      chk("mulhu_out", out, 32'hFFFF_FFFE);
      drain("mulhu");
      run_op("mul",    32'h022081B3, 32'hFFFF_FFFD, 32'd7, 1, 32'hFFFF_FFEB);
      run_op("mulh",   32'h022091B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0000);
      run_op("mulhsu", 32'h0220A1B3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);

      // Divides: 32-cycle loop, specials resolve immediately
      issue(32'h0220C1B3, 32'hFFFF_FFF9, 32'd2);
      chk("div_busy_in_ready", {31'b0, in_ready}, 32'd0);
      wait_valid(40, n);
      chk("div_lat", n, 32);
      chk("div_out", out, 32'hFFFF_FFFD);
      drain("div");
      run_op("rem",      32'h0220E1B3, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF);
      run_op("remu",     32'h0220F1B3, 32'd100, 32'd7, 32, 32'd2);
      run_op("divu",     32'h0220D1B3, 32'd100, 32'd7, 32, 32'd14);
      run_op("divu_by0", 32'h0220D1B3, 32'd55, 32'd0, 0, 32'hFFFF_FFFF);
      run_op("rem_by0",  32'h0220E1B3, 32'h0000_1234, 32'd0, 0, 32'h0000_1234);
      run_op("div_ovf",  32'h0220C1B3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000);
      run_op("rem_ovf",  32'h0220E1B3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h0000_0000);

      // Other illegal encodings
      issue(32'h202081B3, 32'd1, 32'd1);
      chk("bad_f7_illegal", {31'b0, illegal}, 32'd1);
      drain("bad_f7");
      issue(32'h402091B3, 32'd1, 32'd1);
      chk("bad_alt_f3_illegal", {31'b0, illegal}, 32'd1);
      drain("bad_alt_f3");

      // Illegal op, stalled consumer, then back-to-back accept
      issue(32'h0000_0001, 32'd1, 32'd1);
      chk("ill_valid", {31'b0, out_valid}, 32'd1);
      chk("ill_flag", {31'b0, illegal}, 32'd1);
      chk("ill_out", out, 32'd0);
      chk("ill_rd", {27'b0, out_rd}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_valid", {31'b0, out_valid}, 32'd1);
         chk("stall_illegal", {31'b0, illegal}, 32'd1);
         chk("stall_out", out, 32'd0);
         chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      end
      instr     = 32'h002082B3;
      in1       = 32'd10;
      in2       = 32'd20;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("b2b_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("b2b_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_out", out, 32'd30);
      chk("b2b_rd", {27'b0, out_rd}, 32'd5);
      chk("b2b_illegal", {31'b0, illegal}, 32'd0);
      drain("b2b");

      // Reset in the middle of a divide
      issue(32'h0220C1B3, 32'd1000, 32'd3);
      for (int k = 0; k < 9; k++) step();
      chk("mid_div_valid", {31'b0, out_valid}, 32'd0);
      rst = 1'b1;
      step();
      chk("abort_valid", {31'b0, out_valid}, 32'd0);
      chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
      rst = 1'b0;
      #1;
      chk("abort_release_in_ready", {31'b0, in_ready}, 32'd1);
      step();
      chk("abort_stays_idle", {31'b0, out_valid}, 32'd0);
      run_op("after_rst_add", 32'h002081B3, 32'd40, 32'd2, 0, 32'd42);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
